riscv_core_dpath_muldiv_iter: RTL and testbench
===============================================

// Module: riscv_core_dpath_muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the pipelined core datapath, XLEN bits wide.
//  Computes one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
//  Takes operands from X stage via val/rdy request; returns 2*XLEN-bit result via val/rdy response.
//  Adds unsigned and mixed-sign multiply and RISC-V divide-by-zero semantics.
// PARAMETERS
//  XLEN  32  operand width; result is 2*XLEN; must be >=4
// PORTS
//  clk                    in   1       clock
//  reset                  in   1       synchronous, active-high
//  muldivreq_msg_fn       in   3       operation select
//  muldivreq_msg_a        in   XLEN    operand A (multiplicand / dividend)
//  muldivreq_msg_b        in   XLEN    operand B (multiplier / divisor)
//  muldivreq_val          in   1       request valid
//  muldivreq_rdy          out  1       request ready (IDLE only)
//  muldivresp_msg_result  out  2*XLEN  product, or {remainder, quotient}
//  muldivresp_val         out  1       response valid
//  muldivresp_rdy         in   1       response ready
// BEHAVIOUR
//  Reset (clk = clk, synchronous active-high reset): state=IDLE, all regs 0.
//  Reset values: req_rdy=1, resp_val=0, result=0.
//  fn codes:
//   0 MUL    signed*signed
//   1 DIV    signed
//   2 DIVU   unsigned
//   3 REM    signed
//   4 REMU   unsigned
//   5 MULU   unsigned*unsigned
//   6 MULSU  signed A * unsigned B
//   7        illegal: result 0, normal latency
//  Divide-class fns (1-4) all return {rem, quot}.
//  FSM: IDLE -> CALC -> SIGN -> DONE -> IDLE.
//   IDLE: req_rdy=1. On req_val, latch fn, A, B, |A|, |B| and sign flags; clear counter; go to CALC.
//   CALC: XLEN cycles, one step per cycle; 6-bit-wide counter (clog2(XLEN)+1) counts to XLEN-1, then go to SIGN.
//   SIGN: one cycle; conditional two's-complement of the result, then go to DONE.
//   DONE: resp_val=1; result held stable. On resp_rdy, go to IDLE. No accept in DONE: one bubble between ops.
//  Latency: request accepted in cycle t -> resp_val asserted in cycle t+XLEN+2 (34 for XLEN=32).
//  Sign rules:
//   product negated if (A_neg ^ B_neg) for MUL; if A_neg for MULSU.
//   quotient negated if A_neg ^ B_neg; remainder takes the sign of A.
//  Divide by zero (B==0, fns 1-4): quot = all-ones, rem = original A. Sign correction is skipped.
//  Overflow (A = -2^(XLEN-1), B = -1, signed): quot = -2^(XLEN-1), rem = 0.
//  Reset during CALC/SIGN/DONE: abort; in-flight op is discarded with no response. Next cycle: IDLE, resp_val=0.
//  Inputs are ignored while req_rdy=0. resp_val never deasserts without a resp_rdy handshake.
// CONFIGURATION
//  MULDIV_ZERO_EARLY_OUT_EN defined:
//   Request with B==0 (any fn), or A==0 (multiply fns), skips CALC/SIGN and goes IDLE->DONE.
//   Result is registered at accept; resp_val is asserted in cycle t+1.
//   Values are identical to the full path.
//  Not defined: every op takes the full XLEN+2 latency.
// STRUCTURE
//  Shared header riscv-CoreDpathMulDivMsg.v:
//   fn code localparams (MULDIV_FN_MUL..MULDIV_FN_MULSU)
//   FSM state encodings
//   result packing macros.
//  Sub-module riscv_core_dpath_muldiv_step: one combinational iteration.
//   Multiply: conditional add + shift of {acc, multiplier}.
//   Divide: trial subtract + shift of {rem, quot}.
//   Instantiated once, driven by this module's FSM and registers.
// TESTING
//  MUL A=-3, B=7 -> resp_val at t+34, result 64'hFFFF_FFFF_FFFF_FFEB.
//  DIV A=-7, B=2 -> result {32'hFFFF_FFFF, 32'hFFFF_FFFD}; REMU A=7, B=2 -> {32'h1, 32'h3}.
//  DIVU A=7, B=0 -> result {32'h7, 32'hFFFF_FFFF}; with MULDIV_ZERO_EARLY_OUT_EN, resp_val at t+1.
//  DIV A=32'h8000_0000, B=32'hFFFF_FFFF -> result {32'h0, 32'h8000_0000}.
//  Backpressure: resp_rdy=0 for 5 cycles in DONE -> result stable, req_rdy=0; next request accepted the cycle after the handshake.
//  Reset asserted at CALC cycle 10 -> next cycle req_rdy=1, resp_val=0; then MULU 32'hFFFF_FFFF*32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001.

Source files
------------

// File: rtl/riscv_core_dpath_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// FSM state encoding and small fn-classification helpers.
package riscv_core_dpath_muldiv_iter_pkg;

    localparam logic [2:0] MULDIV_FN_MUL   = 3'd0;
    localparam logic [2:0] MULDIV_FN_DIV   = 3'd1;
    localparam logic [2:0] MULDIV_FN_DIVU  = 3'd2;
    localparam logic [2:0] MULDIV_FN_REM   = 3'd3;
    localparam logic [2:0] MULDIV_FN_REMU  = 3'd4;
    localparam logic [2:0] MULDIV_FN_MULU  = 3'd5;
    localparam logic [2:0] MULDIV_FN_MULSU = 3'd6;
    localparam logic [2:0] MULDIV_FN_ILL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic fn_is_mul(input logic [2:0] fn);
        return (fn == MULDIV_FN_MUL) || (fn == MULDIV_FN_MULU) || (fn == MULDIV_FN_MULSU);
    endfunction

    function automatic logic fn_is_div(input logic [2:0] fn);
        return (fn == MULDIV_FN_DIV) || (fn == MULDIV_FN_DIVU) ||
               (fn == MULDIV_FN_REM) || (fn == MULDIV_FN_REMU);
    endfunction

    // Operand A is treated as two's complement for these fns.
    function automatic logic fn_a_signed(input logic [2:0] fn);
        return (fn == MULDIV_FN_MUL) || (fn == MULDIV_FN_DIV) ||
               (fn == MULDIV_FN_REM) || (fn == MULDIV_FN_MULSU);
    endfunction

    function automatic logic fn_b_signed(input logic [2:0] fn);
        return (fn == MULDIV_FN_MUL) || (fn == MULDIV_FN_DIV) || (fn == MULDIV_FN_REM);
    endfunction

endpackage

// File: rtl/riscv_core_dpath_muldiv_iter_step.sv
// One combinational iteration of the unsigned magnitude engine:
// shift-add for multiply, restoring shift-subtract for divide.
module riscv_core_dpath_muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: {hi, lo} = {accumulator, remaining multiplier bits}.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        // Divide: {hi, lo} = {partial remainder, dividend bits / quotient bits}.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_next, lo_next} = {sum, lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/riscv_core_dpath_muldiv_iter.sv
// Iterative XLEN-bit multiply/divide unit (one bit per cycle) with val/rdy request and response.
// Optional MULDIV_ZERO_EARLY_OUT_EN: zero-operand requests bypass CALC/SIGN and respond next cycle.
module riscv_core_dpath_muldiv_iter
    import riscv_core_dpath_muldiv_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        muldivreq_msg_fn,
    input  logic [XLEN-1:0]   muldivreq_msg_a,
    input  logic [XLEN-1:0]   muldivreq_msg_b,
    input  logic              muldivreq_val,
    output logic              muldivreq_rdy,
    output logic [2*XLEN-1:0] muldivresp_msg_result,
    output logic              muldivresp_val,
    input  logic              muldivresp_rdy,
    output muldiv_state_e     state_dbg
);

    // Request is taken on val && rdy (rdy only in IDLE); response is held until val && rdy.
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q;
    muldiv_state_e     state_d;

    logic [2:0]        fn_q;
    logic [XLEN-1:0]   a_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic              b_zero_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] result_q;

    logic              accept;
    logic              early_out;
    logic              req_a_neg;
    logic              req_b_neg;
    logic [XLEN-1:0]   req_a_mag;
    logic [XLEN-1:0]   req_b_mag;
    logic [XLEN-1:0]   hi_step;
    logic [XLEN-1:0]   lo_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [2*XLEN-1:0] result_final;

    assign accept = muldivreq_val && (state_q == ST_IDLE);

`ifdef MULDIV_ZERO_EARLY_OUT_EN
    assign early_out = (muldivreq_msg_b == '0) ||
                       ((muldivreq_msg_a == '0) && fn_is_mul(muldivreq_msg_fn));
`else
    assign early_out = 1'b0;
`endif

    // The engine works on magnitudes; signs are reapplied in SIGN.
    always_comb begin
        req_a_neg = fn_a_signed(muldivreq_msg_fn) && muldivreq_msg_a[XLEN-1];
        req_b_neg = fn_b_signed(muldivreq_msg_fn) && muldivreq_msg_b[XLEN-1];
        req_a_mag = req_a_neg ? -muldivreq_msg_a : muldivreq_msg_a;
        req_b_mag = req_b_neg ? -muldivreq_msg_b : muldivreq_msg_b;
    end

    riscv_core_dpath_muldiv_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div  (fn_is_div(fn_q)),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (operand_q),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (muldivreq_val) state_d = early_out ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_SIGN;
            ST_SIGN: state_d = ST_DONE;
            ST_DONE: if (muldivresp_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        muldivreq_rdy  = (state_q == ST_IDLE);
        muldivresp_val = (state_q == ST_DONE);
    end

    assign muldivresp_msg_result = result_q;
    assign state_dbg             = state_q;

    // Sign correction; divide-by-zero returns the raw dividend and skips it.
    always_comb begin
        prod         = {hi_q, lo_q};
        quot_fix     = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem_fix      = a_neg_q ? -hi_q : hi_q;
        result_final = '0;
        if (fn_is_mul(fn_q)) begin
            result_final = (a_neg_q ^ b_neg_q) ? -prod : prod;
        end else if (fn_is_div(fn_q)) begin
            result_final = b_zero_q ? {a_q, {XLEN{1'b1}}} : {rem_fix, quot_fix};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fn_q      <= '0;
            a_q       <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            operand_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        fn_q     <= muldivreq_msg_fn;
                        a_q      <= muldivreq_msg_a;
                        a_neg_q  <= req_a_neg;
                        b_neg_q  <= req_b_neg;
                        b_zero_q <= (muldivreq_msg_b == '0);
                        cnt_q    <= '0;
                        hi_q     <= '0;
                        if (fn_is_div(muldivreq_msg_fn)) begin
                            lo_q      <= req_a_mag;
                            operand_q <= req_b_mag;
                        end else begin
                            lo_q      <= req_b_mag;
                            operand_q <= req_a_mag;
                        end
`ifdef MULDIV_ZERO_EARLY_OUT_EN
                        if (early_out) begin
                            result_q <= fn_is_div(muldivreq_msg_fn) ?
                                        {muldivreq_msg_a, {XLEN{1'b1}}} : '0;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_SIGN: begin
                    result_q <= result_final;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_dpath_muldiv_iter.sv
// Self-checking bench for riscv_core_dpath_muldiv_iter: directed corner cases plus random ops
// checked every cycle against an arithmetic reference model and expected-result queue.
module tb_riscv_core_dpath_muldiv_iter;
    import riscv_core_dpath_muldiv_iter_pkg::*;

    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    muldivreq_msg_fn = '0;
    logic [31:0]   muldivreq_msg_a = '0;
    logic [31:0]   muldivreq_msg_b = '0;
    logic          muldivreq_val = 1'b0;
    logic          muldivreq_rdy;
    logic [63:0]   muldivresp_msg_result;
    logic          muldivresp_val;
    logic          muldivresp_rdy = 1'b0;
    muldiv_state_e state_dbg;

    riscv_core_dpath_muldiv_iter #(.XLEN(XLEN)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .state_dbg             (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = '0;
        case (fn)
            3'd0: p = sa * sb;
            3'd5: p = ua * ub;
            3'd6: p = sa * ub;
            3'd1, 3'd3: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd2, 3'd4: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = ua / ub;
                    r = ua % ub;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic int latency(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_EARLY_OUT_EN
        if (b == 0 || (a == 0 && (fn == 3'd0 || fn == 3'd5 || fn == 3'd6))) return 1;
`endif
        return FULL_LAT;
    endfunction

    // scoreboard / compare process
    logic [63:0] exp_q[$];
    bit          busy = 1'b0;
    int          due_cyc = 0;
    logic [63:0] last_result = '0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            busy = 1'b0;
        end else begin
            chk("req_rdy", {63'h0, muldivreq_rdy}, {63'h0, !busy});
            chk("resp_val", {63'h0, muldivresp_val}, {63'h0, busy && (cyc >= due_cyc)});
            if (muldivresp_val && exp_q.size() > 0) begin
                chk("result", muldivresp_msg_result, exp_q[0]);
                last_result = muldivresp_msg_result;
                if (muldivresp_rdy) begin
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end
            end
            if (muldivreq_val && muldivreq_rdy) begin
                exp_q.push_back(model(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
                busy    = 1'b1;
                due_cyc = cyc + latency(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b);
            end
        end
    end

    // driver tasks
    task automatic wait_rdy(output bit ok);
        int guard = 0;
        while (!muldivreq_rdy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        ok = muldivreq_rdy;
        if (!ok) begin
            total++; bad++;
            $display("FAIL req_wait: req_rdy stayed 0 for %0d cycles", guard);
        end
    endtask

    task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        bit ok;
        int guard;
        wait_rdy(ok);
        if (!ok) return;
        muldivreq_val    = 1'b1;
        muldivreq_msg_fn = fn;
        muldivreq_msg_a  = a;
        muldivreq_msg_b  = b;
        @(posedge clk); #1;
        guard = 0;
        // garbage on the request side while busy must be ignored
        while (!muldivresp_val && guard < 100) begin
            muldivreq_val    = 1'($urandom_range(0, 1));
            muldivreq_msg_fn = 3'($urandom);
            muldivreq_msg_a  = $urandom;
            muldivreq_msg_b  = $urandom;
            @(posedge clk); #1;
            guard++;
        end
        muldivreq_val = 1'b0;
        if (!muldivresp_val) begin
            total++; bad++;
            $display("FAIL resp_wait: resp_val stayed 0 for %0d cycles", guard);
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        muldivresp_rdy = 1'b1;
        @(posedge clk); #1;
        muldivresp_rdy = 1'b0;
    endtask

    task automatic run_abort(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                             input int calc_cycle);
        bit ok;
        wait_rdy(ok);
        if (!ok) return;
        muldivreq_val    = 1'b1;
        muldivreq_msg_fn = fn;
        muldivreq_msg_a  = a;
        muldivreq_msg_b  = b;
        @(posedge clk); #1;
        muldivreq_val = 1'b0;
        repeat (calc_cycle) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_rdy", {63'h0, muldivreq_rdy}, 64'h1);
        chk("abort_resp_val", {63'h0, muldivresp_val}, 64'h0);
        chk("abort_result", muldivresp_msg_result, 64'h0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", {63'h0, muldivreq_rdy}, 64'h1);
        chk("reset_resp_val", {63'h0, muldivresp_val}, 64'h0);
        chk("reset_result", muldivresp_msg_result, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(MULDIV_FN_MUL, 32'hFFFF_FFFD, 32'd7, 0);
        chk("mul_lit", last_result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(MULDIV_FN_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lit", last_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(MULDIV_FN_REM, 32'hFFFF_FFF9, 32'd2, 1);
        chk("rem_lit", last_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(MULDIV_FN_REMU, 32'd7, 32'd2, 0);
        chk("remu_lit", last_result, {32'h1, 32'h3});
        run_op(MULDIV_FN_DIVU, 32'd7, 32'd0, 0);
        chk("divu_zero_lit", last_result, {32'h7, 32'hFFFF_FFFF});
        run_op(MULDIV_FN_DIV, 32'hFFFF_FFF9, 32'd0, 0);
        chk("div_zero_lit", last_result, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op(MULDIV_FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lit", last_result, {32'h0, 32'h8000_0000});
        run_op(MULDIV_FN_MULSU, 32'hFFFF_FFFE, 32'd3, 5);
        chk("mulsu_bp_lit", last_result, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MULDIV_FN_ILL, 32'd9, 32'd5, 0);
        chk("illegal_lit", last_result, 64'h0);
        run_op(MULDIV_FN_MUL, 32'd0, 32'h1234_5678, 0);
        chk("mul_zero_lit", last_result, 64'h0);

        run_abort(MULDIV_FN_MUL, 32'd123, 32'd456, 10);
        run_op(MULDIV_FN_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mulu_lit", last_result, 64'hFFFF_FFFE_0000_0001);

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
